// File: rtl/loopback_mux_gbe_sched_if.sv
// Source and transmit handshake bundle for the GbE loopback scheduler.
// master: the scheduler (drives src*_ready and tx_*, samples tx_ready).
// slave : the surrounding packetizers and GbE TX port.
interface loopback_mux_gbe_sched_if #(
  parameter int unsigned DATA_W = 64
);
  logic              src0_valid;
  logic [DATA_W-1:0] src0_data;
  logic              src0_eof;
  logic              src0_ready;
  logic              src1_valid;
  logic [DATA_W-1:0] src1_data;
  logic              src1_eof;
  logic              src1_ready;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_eof;
  logic              tx_ready;

  modport master (
    input  src0_valid, src0_data, src0_eof,
    input  src1_valid, src1_data, src1_eof,
    output src0_ready, src1_ready,
    output tx_valid, tx_data, tx_eof,
    input  tx_ready
  );

  modport slave (
    output src0_valid, src0_data, src0_eof,
    output src1_valid, src1_data, src1_eof,
    input  src0_ready, src1_ready,
    input  tx_valid, tx_data, tx_eof,
    output tx_ready
  );
endinterface

// File: rtl/loopback_mux_gbe_sched.sv
// Frame-granular scheduler sharing one 10GbE TX port between the local
// packetizer (src0) and the XAUI loopback path (src1). A granted frame
// always runs to its eof; every frame boundary returns through IDLE.
// Ports:
//   user_clk, user_rst_n : clock, asynchronous active-low reset
//   gbe_over             : [1:0] mode (0 rr, 1 src0, 2 src1, 3 halt), [31] cnt_clr
//   bus (master)         : src0/src1 valid/data/eof/ready, tx valid/data/eof/ready
//   active_src           : 00 idle, 01 src0, 10 src1
//   frames0, frames1     : completed-frame counters per source
module loopback_mux_gbe_sched #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic [31:0]              gbe_over,
  loopback_mux_gbe_sched_if.master bus,
  output logic [1:0]               active_src,
  output logic [CNT_W-1:0]         frames0,
  output logic [CNT_W-1:0]         frames1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RR   = 2'd0;
  localparam logic [1:0] MODE_SRC0 = 2'd1;
  localparam logic [1:0] MODE_SRC1 = 2'd2;

  state_e            state;
  logic              rr;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_eof_q;

  logic [1:0]        mode;
  logic              cnt_clr;
  logic              out_free;
  logic              ready0;
  logic              ready1;
  logic              xfer0;
  logic              xfer1;
  logic              done0;
  logic              done1;
  logic              unused_over;

  assign mode        = gbe_over[1:0];
  assign cnt_clr     = gbe_over[31];
  assign unused_over = ^gbe_over[30:2];

  // Ready follows the output register: a word may enter only if the slot
  // is empty or is being drained this cycle.
  always_comb begin
    out_free   = !tx_valid_q || bus.tx_ready;
    ready0     = (state == GRANT0) && out_free;
    ready1     = (state == GRANT1) && out_free;
    xfer0      = bus.src0_valid && ready0;
    xfer1      = bus.src1_valid && ready1;
    done0      = xfer0 && bus.src0_eof;
    done1      = xfer1 && bus.src1_eof;
    active_src = 2'b00;
    case (state)
      GRANT0:  active_src = 2'b01;
      GRANT1:  active_src = 2'b10;
      default: active_src = 2'b00;
    endcase
  end

  assign bus.src0_ready = ready0;
  assign bus.src1_ready = ready1;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_eof     = tx_eof_q;

  // Grant FSM, output register and frame counters.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state      <= IDLE;
      rr         <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_eof_q   <= 1'b0;
      frames0    <= '0;
      frames1    <= '0;
    end else begin
      if (xfer0) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= bus.src0_data;
        tx_eof_q   <= bus.src0_eof;
      end else if (xfer1) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= bus.src1_data;
        tx_eof_q   <= bus.src1_eof;
      end else if (bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      // Mode is only consulted in IDLE, so a change never splits a frame.
      case (state)
        IDLE: begin
          case (mode)
            MODE_RR: begin
              if (bus.src0_valid && bus.src1_valid) begin
                state <= rr ? GRANT1 : GRANT0;
              end else if (bus.src0_valid) begin
                state <= GRANT0;
              end else if (bus.src1_valid) begin
                state <= GRANT1;
              end
            end
            MODE_SRC0: if (bus.src0_valid) state <= GRANT0;
            MODE_SRC1: if (bus.src1_valid) state <= GRANT1;
            default:   state <= IDLE;
          endcase
        end
        GRANT0: begin
          if (done0) begin
            state <= IDLE;
            rr    <= 1'b1;
          end
        end
        GRANT1: begin
          if (done1) begin
            state <= IDLE;
            rr    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Clear has priority over a same-cycle frame completion.
      if (cnt_clr) begin
        frames0 <= '0;
        frames1 <= '0;
      end else begin
        if (done0) frames0 <= frames0 + CNT_W'(1);
        if (done1) frames1 <= frames1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_loopback_mux_gbe_sched.sv
// Bench for loopback_mux_gbe_sched: cycle-exact vector table plus
// queue-driven frame sequences checked against an expected-word scoreboard.
module tb_loopback_mux_gbe_sched;

  localparam int unsigned DATA_W = 64;
  // Narrow counters so the all-ones wrap is reachable with real frames.
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       gbe_over;
  logic [1:0]        active_src;
  logic [CNT_W-1:0]  frames0;
  logic [CNT_W-1:0]  frames1;

  loopback_mux_gbe_sched_if #(.DATA_W(DATA_W)) bus ();

  loopback_mux_gbe_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .gbe_over   (gbe_over),
    .bus        (bus),
    .active_src (active_src),
    .frames0    (frames0),
    .frames1    (frames1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              eof;
  } word_t;

  typedef struct {
    logic [1:0] mode;
    logic       v0;
    logic [7:0] d0;
    logic       e0;
    logic       v1;
    logic [7:0] d1;
    logic       e1;
    logic       rdy;
    logic       r0;
    logic       r1;
    logic [1:0] act;
    logic       tv;
    logic [7:0] td;
    logic       te;
    logic [3:0] f0;
    logic [3:0] f1;
  } vec_t;

  word_t q0[$];
  word_t q1[$];
  word_t exp_q[$];

  logic [1:0]       mode;
  logic             clr;
  int               n_checks;
  int               n_pass;

  logic             smp_tv;
  logic             smp_r0;
  logic             smp_r1;
  logic [1:0]       smp_act;
  logic [CNT_W-1:0] smp_f0;
  logic [CNT_W-1:0] smp_f1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  task automatic drive_idle_inputs();
    bus.src0_valid = 1'b0;
    bus.src0_data  = '0;
    bus.src0_eof   = 1'b0;
    bus.src1_valid = 1'b0;
    bus.src1_data  = '0;
    bus.src1_eof   = 1'b0;
    bus.tx_ready   = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    mode = 2'd0;
    clr  = 1'b0;
    gbe_over = 32'd0;
    drive_idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive sources from their queues, sample, score tx, advance.
  task automatic cycle(input logic rdy);
    word_t w;
    logic  acc0;
    logic  acc1;
    @(negedge clk);
    gbe_over       = {clr, 29'd0, mode};
    bus.src0_valid = (q0.size() != 0);
    bus.src0_data  = (q0.size() != 0) ? q0[0].data : '0;
    bus.src0_eof   = (q0.size() != 0) ? q0[0].eof : 1'b0;
    bus.src1_valid = (q1.size() != 0);
    bus.src1_data  = (q1.size() != 0) ? q1[0].data : '0;
    bus.src1_eof   = (q1.size() != 0) ? q1[0].eof : 1'b0;
    bus.tx_ready   = rdy;
    #1;
    smp_tv  = bus.tx_valid;
    smp_r0  = bus.src0_ready;
    smp_r1  = bus.src1_ready;
    smp_act = active_src;
    smp_f0  = frames0;
    smp_f1  = frames1;
    if (bus.tx_valid && !bus.tx_ready)
      check("bp_ready", 64'({bus.src1_ready, bus.src0_ready}), 64'd0);
    if (bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got word 0x%0h eof %0b, want none", bus.tx_data, bus.tx_eof);
      end else begin
        w = exp_q.pop_front();
        check("tx_data", bus.tx_data, w.data);
        check("tx_eof", 64'(bus.tx_eof), 64'(w.eof));
      end
    end
    acc0 = bus.src0_valid && bus.src0_ready;
    acc1 = bus.src1_valid && bus.src1_ready;
    @(posedge clk);
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
  endtask

  task automatic drain(input string name, input int max_cycles);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      cycle(1'b1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d words outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic word_t mkw(input int unsigned d, input logic e);
    word_t w;
    w.data = DATA_W'(d);
    w.eof  = e;
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[14];

  initial begin
    int bub;
    int viol;
    bit seen;
    n_checks = 0;
    n_pass   = 0;

    // mode,v0,d0,e0, v1,d1,e1, rdy | r0,r1,act, tv,td,te, f0,f1
    vecs[0]  = '{2'd1, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0};
    vecs[1]  = '{2'd1, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0};
    vecs[2]  = '{2'd1, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'hA0, 1'b0, 4'd0, 4'd0};
    vecs[3]  = '{2'd1, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hA1, 1'b0, 4'd0, 4'd0};
    vecs[4]  = '{2'd1, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hA1, 1'b0, 4'd0, 4'd0};
    vecs[5]  = '{2'd1, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'hA1, 1'b0, 4'd0, 4'd0};
    vecs[6]  = '{2'd1, 1'b1, 8'hA3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'hA2, 1'b0, 4'd0, 4'd0};
    vecs[7]  = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'hA3, 1'b1, 4'd1, 4'd0};
    vecs[8]  = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0};
    vecs[9]  = '{2'd0, 1'b1, 8'hB0, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0};
    vecs[10] = '{2'd0, 1'b1, 8'hB0, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 4'd1, 4'd0};
    vecs[11] = '{2'd0, 1'b1, 8'hB0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'hC0, 1'b1, 4'd1, 4'd1};
    vecs[12] = '{2'd0, 1'b1, 8'hB0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 4'd1, 4'd1};
    vecs[13] = '{2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'hB0, 1'b1, 4'd2, 4'd1};

    // Reset values
    do_reset();
    #1;
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", bus.tx_data, 64'd0);
    check("rst_tx_eof", 64'(bus.tx_eof), 64'd0);
    check("rst_ready0", 64'(bus.src0_ready), 64'd0);
    check("rst_ready1", 64'(bus.src1_ready), 64'd0);
    check("rst_active", 64'(active_src), 64'd0);
    check("rst_frames0", 64'(frames0), 64'd0);
    check("rst_frames1", 64'(frames1), 64'd0);

    // Cycle-exact table: backpressured 4-word frame, then rr single-word frames
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      gbe_over       = {1'b0, 29'd0, vecs[i].mode};
      bus.src0_valid = vecs[i].v0;
      bus.src0_data  = DATA_W'(vecs[i].d0);
      bus.src0_eof   = vecs[i].e0;
      bus.src1_valid = vecs[i].v1;
      bus.src1_data  = DATA_W'(vecs[i].d1);
      bus.src1_eof   = vecs[i].e1;
      bus.tx_ready   = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_ready0", i), 64'(bus.src0_ready), 64'(vecs[i].r0));
      check($sformatf("vec%0d_ready1", i), 64'(bus.src1_ready), 64'(vecs[i].r1));
      check($sformatf("vec%0d_active", i), 64'(active_src), 64'(vecs[i].act));
      check($sformatf("vec%0d_tx_valid", i), 64'(bus.tx_valid), 64'(vecs[i].tv));
      if (vecs[i].tv) begin
        check($sformatf("vec%0d_tx_data", i), bus.tx_data, 64'(vecs[i].td));
        check($sformatf("vec%0d_tx_eof", i), 64'(bus.tx_eof), 64'(vecs[i].te));
      end
      check($sformatf("vec%0d_frames0", i), 64'(frames0), 64'(vecs[i].f0));
      check($sformatf("vec%0d_frames1", i), 64'(frames1), 64'(vecs[i].f1));
      @(posedge clk);
    end

    // Round-robin, both sources with continuous 3-word frames
    do_reset();
    mode = 2'd0;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 3; w++) begin
        q0.push_back(mkw(32'h100 + 32'(f * 16 + w), w == 2));
        q1.push_back(mkw(32'h200 + 32'(f * 16 + w), w == 2));
      end
    end
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 3; w++) exp_q.push_back(mkw(32'h100 + 32'(f * 16 + w), w == 2));
      for (int w = 0; w < 3; w++) exp_q.push_back(mkw(32'h200 + 32'(f * 16 + w), w == 2));
    end
    bub  = 0;
    seen = 1'b0;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      cycle(1'b1);
      if (smp_tv) seen = 1'b1;
      else if (seen) bub++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL rr_timeout: got %0d words outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    check("rr_bubbles", 64'(bub), 64'd3);
    cycle(1'b1);
    check("rr_frames0", 64'(smp_f0), 64'd2);
    check("rr_frames1", 64'(smp_f1), 64'd2);

    // Mode 1 blocks a streaming src1; switching to mode 0 grants it
    do_reset();
    mode = 2'd1;
    for (int f = 0; f < 10; f++) begin
      q1.push_back(mkw(32'h300 + 32'(f * 16), 1'b0));
      q1.push_back(mkw(32'h301 + 32'(f * 16), 1'b1));
    end
    viol = 0;
    repeat (20) begin
      cycle(1'b1);
      if (smp_r1 || smp_tv) viol++;
    end
    check("m1_blocked_cycles", 64'(viol), 64'd0);
    check("m1_frames1", 64'(smp_f1), 64'd0);
    mode  = 2'd0;
    exp_q = q1;
    cycle(1'b1);
    cycle(1'b1);
    check("m0_grant_src1", 64'(smp_act), 64'b10);
    drain("m0_stream", 80);
    check("m0_frames1", 64'(smp_f1), 64'd10);

    // Mode 0 -> 3 mid-frame: frame completes, then FSM holds IDLE
    do_reset();
    mode = 2'd0;
    for (int w = 0; w < 5; w++) q0.push_back(mkw(32'h400 + 32'(w), w == 4));
    exp_q = q0;
    repeat (3) cycle(1'b1);
    mode = 2'd3;
    drain("halt_drain", 20);
    q0.push_back(mkw(32'h4FF, 1'b1));
    viol = 0;
    repeat (4) begin
      cycle(1'b1);
      if (smp_act != 2'b00 || smp_r0) viol++;
    end
    check("halt_idle_cycles", 64'(viol), 64'd0);
    check("halt_frames0", 64'(smp_f0), 64'd1);

    // Counter wrap and clear-versus-increment
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 15; i++) begin
      q0.push_back(mkw(32'h500 + 32'(i), 1'b1));
      exp_q.push_back(mkw(32'h500 + 32'(i), 1'b1));
    end
    drain("cnt_fill", 80);
    cycle(1'b1);
    check("cnt_full", 64'(smp_f0), 64'hF);
    q0.push_back(mkw(32'h5F0, 1'b1));
    exp_q.push_back(mkw(32'h5F0, 1'b1));
    drain("cnt_wrap", 10);
    cycle(1'b1);
    check("cnt_wrap", 64'(smp_f0), 64'd0);
    q0.push_back(mkw(32'h600, 1'b1));
    exp_q.push_back(mkw(32'h600, 1'b1));
    drain("cnt_pre", 10);
    cycle(1'b1);
    check("cnt_pre_clr", 64'(smp_f0), 64'd1);
    q0.push_back(mkw(32'h601, 1'b1));
    exp_q.push_back(mkw(32'h601, 1'b1));
    cycle(1'b1);
    clr = 1'b1;
    cycle(1'b1);
    check("clr_eof_xfer", 64'(smp_r0), 64'd1);
    clr = 1'b0;
    cycle(1'b1);
    check("clr_wins", 64'(smp_f0), 64'd0);
    drain("clr_drain", 5);

    // Asynchronous reset while word 2 of a frame sits in the output register
    do_reset();
    mode = 2'd1;
    q0.push_back(mkw(32'h700, 1'b1));
    for (int w = 0; w < 4; w++) q0.push_back(mkw(32'h710 + 32'(w), w == 3));
    exp_q.push_back(mkw(32'h700, 1'b1));
    exp_q.push_back(mkw(32'h710, 1'b0));
    drain("rst_pre", 30);
    @(negedge clk);
    #1;
    check("rst_pre_valid", 64'(bus.tx_valid), 64'd1);
    check("rst_pre_data", bus.tx_data, 64'h711);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_async_active", 64'(active_src), 64'd0);
    do_reset();
    mode = 2'd0;
    q0.push_back(mkw(32'h800, 1'b1));
    q1.push_back(mkw(32'h900, 1'b1));
    exp_q.push_back(mkw(32'h800, 1'b1));
    exp_q.push_back(mkw(32'h900, 1'b1));
    cycle(1'b1);
    check("rst_after_idle", 64'(smp_act), 64'd0);
    drain("rst_after", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/loopback_mux_gbe_sched.md
# loopback_mux_gbe_sched

Frame-granular scheduler that shares the single 10GbE transmit port between the local packetizer (src0) and the XAUI loopback path (src1). The software override register `loopback_mux_gbe_over` supplies its 32-bit control word. The scheduler returns per-source frame counters to the CPU through `opb_register_simulink2ppc` status registers. It sits in the `user_clk` domain between the packetizers and the GbE TX interface and never splits a frame.

## Interface
Parameters:
- `DATA_W`, 64: width of the frame data word.
- `CNT_W`, 32: width of each frame counter.

Ports:
- `user_clk`  in  1  sole clock; every flop is clocked on its rising edge.
- `user_rst_n`  in  1  asynchronous, active-low reset.
- `gbe_over`  in  32  control word from the override register.
  - [1:0] mode: 0 = round-robin, 1 = src0 only, 2 = src1 only, 3 = halt.
  - [31] `cnt_clr`, level-sensitive.
  - All other bits are ignored.
- `src0_valid`, `src1_valid`  in  1  source presents a word.
- `src0_data`, `src1_data`  in  DATA_W  source word.
- `src0_eof`, `src1_eof`  in  1  word is the last of its frame.
- `src0_ready`, `src1_ready`  out  1  scheduler accepts the word this cycle.
- `tx_valid`  out  1  output register holds a word.
- `tx_data`  out  DATA_W  output word.
- `tx_eof`  out  1  output word is the last of its frame.
- `tx_ready`  in  1  GbE port accepts the word this cycle.
- `active_src`  out  2  current owner: 00 idle, 01 src0, 10 src1.
- `frames0`, `frames1`  out  CNT_W  completed-frame counts per source.

## Operation
- The FSM has three states: IDLE, GRANT0, GRANT1. The rr pointer `rr` is 1 bit; 0 means src0 has priority.
- Decisions in IDLE (mode is sampled only here):
  - Mode 0: if both sources are valid, grant src`rr`; otherwise grant whichever source is valid.
  - Mode 1: go to GRANT0 if `src0_valid`; src1 is ignored.
  - Mode 2: the mirror of mode 1 (GRANT1 if `src1_valid`).
  - Mode 3: stay in IDLE.
  - With no eligible request, stay in IDLE.
- GRANTx behaviour:
  - `srcx_ready` = !`tx_valid` || `tx_ready`. The other source's ready is 0.
  - A transfer occurs when `srcx_valid` && `srcx_ready`. On a transfer the word and eof are loaded into the output register.
  - Transfer with eof=1:
    - Go to IDLE.
    - Set `rr` to the other source.
    - Increment `framesx`.
- A mode change during a frame takes effect at the next IDLE. The current frame always completes; mode 3 therefore drains gracefully.
- Output register:
  - `tx_valid` sets on a transfer.
  - When `tx_ready` is high and no new transfer occurs, `tx_valid` clears.
  - `tx_data`/`tx_eof` hold while `tx_valid`=1 && `tx_ready`=0.
- Counters:
  - Width CNT_W, unsigned, wrap from 2^CNT_W-1 to 0.
  - `cnt_clr`=1 zeroes both counters every cycle it is high. Clear wins over a simultaneous increment.
- `active_src` is decoded from the state.
- Ready signals are 0 in IDLE.

## Timing
- Reset values:
  - State IDLE, `rr`=0.
  - `tx_valid`=0, `tx_data`=0, `tx_eof`=0.
  - `src0_ready`=`src1_ready`=0.
  - `active_src`=00.
  - `frames0`=`frames1`=0.
- Reset asserted mid-frame aborts the frame immediately. `tx_valid` drops asynchronously and no eof is emitted.
- Grant latency:
  - A request seen in IDLE at cycle n moves the FSM to GRANTx at n+1.
  - The first accept is at n+1. The word appears on `tx_*` at n+2.
- Data latency is one cycle from accept to `tx_valid`. Throughput is 1 word/cycle while `tx_ready` stays high.
- Each frame boundary costs exactly one IDLE bubble cycle.
- Backpressure: if `tx_ready`=0 while `tx_valid`=1, `srcx_ready`=0 in the same cycle. No word is lost or duplicated.
- A single-word frame (valid with eof on the first word) takes GRANT for exactly one transfer cycle.

## Test plan
- Reset, then mode 0 with both sources requesting 3-word frames continuously:
  - `tx` shows the sequence src0, src1, src0, src1 with one bubble between frames.
  - After 4 frames, `frames0`=2 and `frames1`=2.
- Mode 1 with src1 streaming 10 frames:
  - `src1_ready` stays 0 and `tx_valid` stays 0.
  - `frames1` stays 0.
  - Switching to mode 0 grants src1 on the next IDLE.
- Mode change 0→3 in the middle of a 5-word src0 frame:
  - All 5 words are output and eof is seen.
  - The FSM then holds IDLE and `frames0` increments by 1.
- `tx_ready` toggling 1,0,0,1 during a 4-word frame:
  - Output order and data are exact.
  - `src0_ready` is 0 on every cycle where `tx_valid`=1 && `tx_ready`=0.
- Counter edge cases:
  - Preload `frames0` to 0xFFFFFFFF via frames; the next src0 eof gives 0.
  - Assert `cnt_clr` on the same cycle as an eof; the count is 0.
- Assert `user_rst_n` low while word 2 of a frame is in the output register:
  - `tx_valid`=0 asynchronously.
  - After release, state is IDLE, `rr`=0, and the next grant goes to src0 when both sources request.
